// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, load/store port and memory-array side of the
// unified memory arbiter; "slave" is the arbiter's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_kill;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              stall_if;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              stall_mem;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output i_req, i_addr, i_kill,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, stall_if,
        input  d_gnt, d_rvalid, d_rdata, stall_mem,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  i_req, i_addr, i_kill,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output i_gnt, i_rvalid, i_rdata, stall_if,
        output d_gnt, d_rvalid, d_rdata, stall_mem,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store; data wins by default.
// Optional fetch anti-starvation counter enabled by defining MEMARB_ANTISTARVE_EN.
//
//   respQ    | meaning
//   RespNone | no read data returns this cycle
//   RespIf   | mem_rdata belongs to the fetch port
//   RespMem  | mem_rdata belongs to the load port
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        RespNone = 2'd0,
        RespIf   = 2'd1,
        RespMem  = 2'd2
    } respState_t;

    respState_t respQ;
    logic       iGnt;
    logic       dGnt;
    logic       forceFetch;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadStarveMax
        $error("mem_port_arbiter: STARVE_MAX must be within 1..15");
    end

`ifdef MEMARB_ANTISTARVE_EN
    localparam logic [3:0] StarveLimit = 4'(STARVE_MAX);
    logic [3:0] starveQ;

    // Counts consecutive cycles a fetch has been waiting; saturates at 15.
    always_ff @(posedge clk) begin
        if (reset) begin
            starveQ <= '0;
        end else if (iGnt || !bus.i_req) begin
            starveQ <= '0;
        end else if (starveQ != 4'hF) begin
            starveQ <= starveQ + 4'd1;
        end
    end

    assign forceFetch = bus.i_req && (starveQ >= StarveLimit);
`else
    assign forceFetch = 1'b0;
`endif

    always_comb begin
        iGnt = 1'b0;
        dGnt = 1'b0;
        if (!reset) begin
            if (bus.d_req && !forceFetch) begin
                dGnt = 1'b1;
            end else if (bus.i_req) begin
                iGnt = 1'b1;
            end
        end
    end

    // A read granted while reset is high must never come back as valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            respQ <= RespNone;
        end else if (iGnt) begin
            respQ <= RespIf;
        end else if (dGnt && !bus.d_we) begin
            respQ <= RespMem;
        end else begin
            respQ <= RespNone;
        end
    end

    assign bus.i_gnt     = iGnt;
    assign bus.d_gnt     = dGnt;
    assign bus.stall_if  = bus.i_req && !iGnt && !reset;
    assign bus.stall_mem = bus.d_req && !dGnt && !reset;

    assign bus.mem_en    = iGnt || dGnt;
    assign bus.mem_we    = dGnt && bus.d_we;
    assign bus.mem_addr  = dGnt ? bus.d_addr : (iGnt ? bus.i_addr : '0);
    assign bus.mem_wdata = dGnt ? bus.d_wdata : '0;

    assign bus.i_rvalid  = (respQ == RespIf) && !bus.i_kill;
    assign bus.d_rvalid  = (respQ == RespMem);
    assign bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors with literal expectations plus
// a per-cycle reference model of the arbitration and response rules.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 3;
`ifdef MEMARB_ANTISTARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passCount  = 0;
    int totalCount = 0;

    // Model state: who owns the read data arriving now (0 none, 1 fetch, 2 data)
    // and how many consecutive cycles fetch has been refused.
    int ownerNow  = 0;
    int ownerNext = 0;
    int runNow    = 0;
    int runNext   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        int win;
        logic expIV, expDV;
        win = 0;
        if (!reset) begin
            if (bus.i_req && ANTI && runNow >= SMAX) win = 1;
            else if (bus.d_req) win = 2;
            else if (bus.i_req) win = 1;
        end
        expIV = (ownerNow == 1) && !bus.i_kill;
        expDV = (ownerNow == 2);
        check("m_i_gnt", bus.i_gnt, win == 1);
        check("m_d_gnt", bus.d_gnt, win == 2);
        check("m_stall_if", bus.stall_if, !reset && bus.i_req && win != 1);
        check("m_stall_mem", bus.stall_mem, !reset && bus.d_req && win != 2);
        check("m_mem_en", bus.mem_en, win != 0);
        check("m_mem_we", bus.mem_we, win == 2 && bus.d_we);
        check("m_mem_addr", bus.mem_addr, win == 2 ? bus.d_addr : (win == 1 ? bus.i_addr : 32'd0));
        check("m_mem_wdata", bus.mem_wdata, win == 2 ? bus.d_wdata : 32'd0);
        check("m_i_rvalid", bus.i_rvalid, expIV);
        check("m_d_rvalid", bus.d_rvalid, expDV);
        check("m_i_rdata", bus.i_rdata, expIV ? bus.mem_rdata : 32'd0);
        check("m_d_rdata", bus.d_rdata, expDV ? bus.mem_rdata : 32'd0);
        if (reset) ownerNext = 0;
        else if (win == 1) ownerNext = 1;
        else if (win == 2 && !bus.d_we) ownerNext = 2;
        else ownerNext = 0;
        if (reset || !bus.i_req || win == 1) runNext = 0;
        else runNext = (runNow < 15) ? runNow + 1 : 15;
    end

    always @(posedge clk) begin
        ownerNow = ownerNext;
        runNow   = runNext;
    end

    task automatic drive(input logic rst, input logic ireq, input logic [AW-1:0] iaddr,
                         input logic ikill, input logic dreq, input logic dwe,
                         input logic [AW-1:0] daddr, input logic [DW-1:0] dwdata,
                         input logic [DW-1:0] rdata);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.i_req     = ireq;
        bus.i_addr    = iaddr;
        bus.i_kill    = ikill;
        bus.d_req     = dreq;
        bus.d_we      = dwe;
        bus.d_addr    = daddr;
        bus.d_wdata   = dwdata;
        bus.mem_rdata = rdata;
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.i_req = 0; bus.i_addr = '0; bus.i_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0;

        // Reset for two cycles; a fetch request during reset is not granted.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 0, 32'h40, 0, 0);
        check("rst_i_gnt", bus.i_gnt, 0);
        check("rst_d_gnt", bus.d_gnt, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_stall_if", bus.stall_if, 0);
        check("rst_stall_mem", bus.stall_mem, 0);

        // Fetch only.
        drive(0, 1, 32'h0, 0, 0, 0, 0, 0, 32'h00500113);
        check("f_i_gnt", bus.i_gnt, 1);
        check("f_i_rvalid0", bus.i_rvalid, 0);
        check("f_i_rdata0", bus.i_rdata, 0);
        drive(0, 1, 32'h4, 0, 0, 0, 0, 0, 32'h00500113);
        check("f_i_rvalid", bus.i_rvalid, 1);
        check("f_i_rdata", bus.i_rdata, 32'h00500113);
        check("f_d_rvalid", bus.d_rvalid, 0);

        // Conflict: load beats fetch, fetch follows.
        drive(0, 1, 32'h8, 0, 1, 0, 32'h60, 0, 32'h11);
        check("c_d_gnt", bus.d_gnt, 1);
        check("c_stall_if", bus.stall_if, 1);
        check("c_mem_addr", bus.mem_addr, 32'h60);
        check("c_mem_we", bus.mem_we, 0);
        drive(0, 1, 32'h8, 0, 0, 0, 0, 0, 32'h22);
        check("c_d_rvalid", bus.d_rvalid, 1);
        check("c_d_rdata", bus.d_rdata, 32'h22);
        check("c_i_gnt", bus.i_gnt, 1);
        check("c_mem_addr2", bus.mem_addr, 32'h8);

        // Store.
        drive(0, 0, 0, 0, 1, 1, 32'd100, 32'd25, 32'h33);
        check("s_mem_we", bus.mem_we, 1);
        check("s_mem_addr", bus.mem_addr, 32'd100);
        check("s_mem_wdata", bus.mem_wdata, 32'd25);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h44);
        check("s_d_rvalid", bus.d_rvalid, 0);

        // Kill squashes only the returning fetch.
        drive(0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h55);
        check("k_i_gnt0", bus.i_gnt, 1);
        drive(0, 1, 32'h14, 1, 0, 0, 0, 0, 32'h66);
        check("k_i_rvalid", bus.i_rvalid, 0);
        check("k_i_gnt1", bus.i_gnt, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h77);
        check("k_i_rvalid2", bus.i_rvalid, 1);
        check("k_i_rdata2", bus.i_rdata, 32'h77);

        // Continuous contention.
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 32'h20, 0, 1, 0, 32'h80, 0, 32'(k));
            if (ANTI) begin
                check("sv_i_gnt", bus.i_gnt, (k % 4) == 3);
                check("sv_stall_mem", bus.stall_mem, (k % 4) == 3);
            end else begin
                check("sv_i_gnt", bus.i_gnt, 0);
            end
        end

        // Reset asserted with a load request pending.
        drive(1, 0, 0, 0, 1, 0, 32'h90, 0, 32'h88);
        check("r_d_gnt", bus.d_gnt, 0);
        check("r_mem_en", bus.mem_en, 0);
        check("r_mem_addr", bus.mem_addr, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h99);
        check("r_d_rvalid", bus.d_rvalid, 0);
        check("r_i_rvalid", bus.i_rvalid, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified instruction/data memory of the RVX10 five-stage pipeline between the IF-stage fetch port and the MEM-stage load/store port. It sits between `top_pipeline`'s core and the memory array. It issues at most one memory access per cycle, routes synchronous-read data back to the correct requester one cycle later, and raises stall outputs consumed by the hazard logic. An anti-starvation counter can be compiled in so that a long burst of data accesses cannot block fetch indefinitely.

## Interface
- `ADDR_W`, default 32: byte address width on all ports.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 3: consecutive denied fetch cycles before fetch is forced to win. Used only with `MEMARB_ANTISTARVE_EN`. Legal range is 1..15.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: fetch read request.
- `i_addr` in `ADDR_W`: fetch address.
- `i_kill` in 1: branch/jump flush; squashes a fetch response returning this cycle.
- `i_gnt` out 1: fetch granted this cycle.
- `i_rvalid` out 1: fetch data valid.
- `i_rdata` out `DATA_W`: fetch data.
- `stall_if` out 1: equals `i_req & ~i_gnt`.
- `d_req` in 1: data access request.
- `d_we` in 1: 1 means store, 0 means load.
- `d_addr` in `ADDR_W`: data address.
- `d_wdata` in `DATA_W`: store data.
- `d_gnt` out 1: data granted this cycle.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out `DATA_W`: load data.
- `stall_mem` out 1: equals `d_req & ~d_gnt`.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: memory read data, valid the cycle after a read with `mem_en=1`.

## Operation
- Grants are combinational from the current requests and registered state. At most one of `i_gnt`/`d_gnt` is high per cycle.
- Default priority: data beats fetch, because the MEM-stage instruction is older.
- Memory side mirrors the winner:
  - `mem_en = i_gnt | d_gnt`.
  - `mem_we = d_gnt & d_we`.
  - `mem_addr`/`mem_wdata` come from the winning port.
  - When no port is granted, `mem_addr`/`mem_wdata` are 0.
- Response-owner register `resp_q` holds one of three states:
  - `NONE`: next state after a cycle with no read grant, or after a store grant.
  - `IF`: next state after a cycle with `i_gnt`.
  - `MEM`: next state after a cycle with `d_gnt & ~d_we`.
- Response outputs:
  - `i_rvalid = (resp_q==IF) & ~i_kill`.
  - `d_rvalid = (resp_q==MEM)`.
  - `i_rdata` and `d_rdata` are both driven from `mem_rdata` when their valid is high, and are 0 otherwise.
- Stores complete in their grant cycle and produce no `d_rvalid`.
- `i_kill` affects only the response in the current cycle. A new fetch granted in the same cycle proceeds normally.
- Starvation counter `starve_q` (4 bits):
  - Increments on each cycle with `i_req & ~i_gnt`.
  - Clears on `i_gnt` or `~i_req`.
  - Saturates at 15.

## Timing
- Grant latency is 0 cycles (same cycle as the request). Read latency is 1 cycle from grant to rvalid.
- A requester holds `req`/address stable until it sees its grant.
- A back-to-back grant to the same or the other port is legal every cycle. Responses never overlap because only one grant is issued per cycle.
- Simultaneous `i_req` and `d_req`: data wins. Fetch sees `stall_if=1` and its request stays pending.
- With reset high, registered state takes its reset values at the next rising edge. Values in the cycle after that edge:
  - `resp_q=NONE`, `starve_q=0`.
  - `i_rvalid`, `d_rvalid`, `i_rdata`, `d_rdata` are 0.
- A read granted in the cycle reset is asserted never returns a valid.
- While reset is high:
  - `i_gnt`, `d_gnt`, `mem_en`, `mem_we` are forced to 0.
  - `stall_if` and `stall_mem` are forced to 0.
  - `mem_addr` and `mem_wdata` are 0.

## Configuration
- `MEMARB_ANTISTARVE_EN` defined:
  - When `starve_q >= STARVE_MAX` and `i_req` is high, fetch wins that cycle even if `d_req` is high.
  - `stall_mem=1` for that cycle, and `starve_q` clears.
- `MEMARB_ANTISTARVE_EN` undefined:
  - `starve_q` is not built.
  - Data always wins, so fetch can starve under continuous `d_req`.

## Test plan
- Reset, then fetch only. Stimulus: reset for 2 cycles; `i_req=1`, `i_addr=0x0`; `mem_rdata=0x00500113`. Required: `i_gnt=1` in the first cycle after reset; `i_rvalid=1` with `i_rdata=0x00500113` next cycle; `d_rvalid` stays 0.
- Conflict. Stimulus: `i_req=1` `i_addr=0x8` together with a load `d_req=1` `d_addr=0x60`. Required in the conflict cycle: `d_gnt=1`, `stall_if=1`, `mem_addr=0x60`, `mem_we=0`. Next cycle: `d_rvalid=1`, `i_gnt=1`, `mem_addr=0x8`.
- Store. Stimulus: `d_req=1`, `d_we=1`, `d_addr=100`, `d_wdata=25`. Required: `mem_we=1`, `mem_addr=100`, `mem_wdata=25` in the same cycle; `d_rvalid=0` the following cycle.
- Kill. Stimulus: fetch granted in cycle N; `i_kill=1` in N+1. Required: `i_rvalid=0` in N+1; a new fetch granted in N+1 returns `i_rvalid=1` in N+2.
- Starvation (macro on, `STARVE_MAX=3`). Stimulus: `d_req` and `i_req` held high continuously. Required: `d_gnt` for 3 cycles, then `i_gnt=1` with `stall_mem=1` on the 4th cycle, repeating with period 4. With the macro off: `i_gnt` stays 0 throughout.
- Reset mid-read. Stimulus: load granted and `reset=1` in the same cycle. Required: `d_rvalid=0` the next cycle; all grants and `mem_en` are 0 while reset is high.
